// File: rtl/piso_serializer_if.sv
// piso_serializer_if: word handshake, shift strobe and serial output of the PISO transmitter.
interface piso_serializer_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             dir;
    logic             en;
    logic             sdo;
    logic             sdo_valid;
    logic             last;
    logic             busy;
    modport master (output in_valid, in_data, dir, en, input in_ready, sdo, sdo_valid, last, busy);
    modport slave  (input in_valid, in_data, dir, en, output in_ready, sdo, sdo_valid, last, busy);
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out transmitter, one bit per en strobe, MSB- or LSB-first.
module piso_serializer #(parameter int WIDTH = 8) (
    input logic clk,
    input logic rstn,
    piso_serializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state;
    logic [WIDTH-1:0] sh;
    logic             dir_q;
    logic [CW-1:0]    cnt;
    logic             shifting;
    logic             fin;
    logic             accept;
    // outputs are gated by rstn so they read low for the whole reset window
    assign shifting      = rstn && state == SHIFT;
    assign fin           = shifting && cnt == LAST;
    assign bus.in_ready  = rstn && (state == IDLE || (fin && bus.en));
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.sdo       = shifting && (dir_q ? sh[0] : sh[WIDTH-1]);
    assign bus.sdo_valid = shifting;
    assign bus.busy      = shifting;
    assign bus.last      = fin;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            sh    <= '0;
            dir_q <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            sh    <= bus.in_data;
            dir_q <= bus.dir;
            cnt   <= '0;
            state <= SHIFT;
        end else if (state == SHIFT && bus.en) begin
            if (cnt == LAST) begin
                state <= IDLE;
                sh    <= '0;
                cnt   <= '0;
            end else begin
                sh  <= dir_q ? {1'b0, sh[WIDTH-1:1]} : {sh[WIDTH-2:0], 1'b0};
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: random and directed stimulus checked every cycle against a bit-list model.
module tb_piso_serializer;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int errors = 0;
    int checks = 0;
    piso_serializer_if #(.WIDTH(W)) bus();
    piso_serializer #(.WIDTH(W)) dut (.clk(clk), .rstn(rstn), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // model: the word as a list of bits in transmit order, plus how many have been consumed
    logic m_bits [W];
    bit   m_act = 1'b0;
    int   m_pos = 0;

    function automatic logic m_ready();
        return rstn && (!m_act || (m_pos == W - 1 && bus.en));
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            m_act <= 1'b0;
            m_pos <= 0;
        end else if (bus.in_valid && m_ready()) begin
            for (int i = 0; i < W; i++) m_bits[i] <= bus.dir ? bus.in_data[i] : bus.in_data[W-1-i];
            m_act <= 1'b1;
            m_pos <= 0;
        end else if (m_act && bus.en) begin
            if (m_pos == W - 1) m_act <= 1'b0;
            else m_pos <= m_pos + 1;
        end
    end

    always @(negedge clk) begin
        chk("sdo", bus.sdo, (rstn && m_act) ? m_bits[m_pos] : 1'b0);
        chk("sdo_valid", bus.sdo_valid, rstn && m_act);
        chk("busy", bus.busy, rstn && m_act);
        chk("last", bus.last, rstn && m_act && m_pos == W - 1);
        chk("in_ready", bus.in_ready, m_ready());
    end

    // matching serial-in receiver for loopback
    logic [W-1:0] rx;
    int           rx_n;
    logic         rx_dir = 1'b0;
    logic         rx_clr = 1'b0;
    always @(posedge clk) begin
        if (rx_clr) begin
            rx   <= '0;
            rx_n <= 0;
        end else if (bus.en && bus.sdo_valid) begin
            rx   <= rx_dir ? {bus.sdo, rx[W-1:1]} : {rx[W-2:0], bus.sdo};
            rx_n <= rx_n + 1;
        end
    end

    logic [31:0] seq, lastp, readyp;
    int nv;

    initial begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hC1;
        bus.dir      = 1'b0;
        bus.en       = 1'b1;
        tick();
        tick();
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_sdo", bus.sdo, 0);
        chk("rst_valid", bus.sdo_valid, 0);
        chk("rst_busy", bus.busy, 0);
        bus.in_valid = 1'b0;
        rstn = 1'b1;
        #1;
        chk("post_rst_ready", bus.in_ready, 1);
        chk("post_rst_busy", bus.busy, 0);
        tick();

        for (int d = 0; d < 2; d++) begin
            bus.in_data  = 8'hC1;
            bus.dir      = d[0];
            bus.en       = 1'b1;
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            seq = 0;
            lastp = 0;
            for (int i = 0; i < W; i++) begin
                seq   = {seq[30:0], bus.sdo};
                lastp = {lastp[30:0], bus.last};
                bus.dir     = ~bus.dir;
                bus.in_data = 8'($urandom);
                tick();
            end
            chk(d ? "lsb_seq" : "msb_seq", seq, d ? 32'h83 : 32'hC1);
            chk("last_only_final", lastp, 32'h1);
            chk("end_valid", bus.sdo_valid, 0);
            chk("end_ready", bus.in_ready, 1);
        end

        bus.in_data  = 8'hC1;
        bus.dir      = 1'b0;
        bus.en       = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        seq = 0;
        nv  = 0;
        for (int k = 0; k < 40; k++) begin
            bus.en = k[0];
            if (bus.sdo_valid) begin
                nv++;
                if (bus.en) seq = {seq[30:0], bus.sdo};
            end
            tick();
        end
        chk("half_rate_len", nv, 16);
        chk("half_rate_seq", seq, 32'hC1);

        bus.en       = 1'b1;
        bus.in_data  = 8'hC1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        seq    = 0;
        readyp = 0;
        nv     = 0;
        for (int i = 0; i < 2 * W; i++) begin
            if (i == 2) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 8'h0F;
            end
            if (i == W) bus.in_valid = 1'b0;
            #1;
            seq    = {seq[30:0], bus.sdo};
            readyp = {readyp[30:0], bus.in_ready};
            if (bus.sdo_valid) nv++;
            tick();
        end
        chk("b2b_seq", seq, 32'hC10F);
        chk("b2b_ready", readyp, 32'h0101);
        chk("b2b_valid", nv, 16);

        bus.in_data  = 8'h5A;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        rstn = 1'b0;
        tick();
        chk("abort_valid", bus.sdo_valid, 0);
        chk("abort_busy", bus.busy, 0);
        rstn = 1'b1;
        #1;
        chk("abort_idle_busy", bus.busy, 0);
        chk("abort_idle_ready", bus.in_ready, 1);
        chk("abort_idle_valid", bus.sdo_valid, 0);
        tick();

        for (int d = 0; d < 2; d++) begin
            rx_clr = 1'b1;
            tick();
            rx_clr       = 1'b0;
            rx_dir       = d[0];
            bus.dir      = d[0];
            bus.in_data  = 8'h5A;
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            for (int i = 0; i < 200 && bus.busy; i++) begin
                bus.en  = 1'($urandom_range(0, 1));
                bus.dir = 1'($urandom);
                tick();
            end
            chk("loop_done", bus.busy, 0);
            chk("loop_word", rx, 8'h5A);
            chk("loop_bits", rx_n, W);
        end

        for (int i = 0; i < 3000; i++) begin
            rstn         = $urandom_range(0, 63) != 0;
            bus.in_valid = 1'($urandom);
            bus.in_data  = 8'($urandom);
            bus.dir      = 1'($urandom);
            bus.en       = $urandom_range(0, 3) != 0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
